fetch_unit: RTL

Instruction-fetch stage for the 16-bit multicycle/pipelined CPU. It owns the PC and issues instruction-memory reads with a request/ready handshake. Fetch pauses while the DMA controller holds the bus. Returned words are captured into the IF/ID register, whose instruction output feeds decode and immediate sign-extension. A one-entry skid buffer absorbs a word that returns while decode is stalled.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read port between fetch_unit and memory
interface fetch_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;

  modport master (output i_readM, output i_address, input i_data, input i_ready);
  modport slave  (input i_readM, input i_address, output i_data, output i_ready);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, instruction-memory requester, IF/ID register with one-entry skid buffer
module fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_unit_if.master         imem,
  input  logic                 bus_granted,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] pc_plus1_out,
  output logic                 instr_valid
);

  typedef enum logic {S_REQ, S_BUF} state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] buf_instr_q, buf_instr_d;
  logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] pc_out_q, pc_out_d;
  logic [WORD_SIZE-1:0] pc_p1_q, pc_p1_d;
  logic                 valid_q, valid_d;

  logic                 read_req;
  logic                 accept;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] buf_pc_inc;

  assign read_req       = reset_n && (state_q == S_REQ) && !bus_granted;
  assign accept         = read_req && imem.i_ready;
  assign pc_inc         = pc_q + ONE;
  assign buf_pc_inc     = buf_pc_q + ONE;

  assign imem.i_readM   = read_req;
  assign imem.i_address = pc_q;

  assign instr_out      = instr_q;
  assign pc_out         = pc_out_q;
  assign pc_plus1_out   = pc_p1_q;
  assign instr_valid    = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    pc_p1_d     = pc_p1_q;
    valid_d     = valid_q;

    // A redirect wins over any word returned this cycle and flushes the skid buffer.
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = S_REQ;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_d = pc_inc;
            if (!stall) begin
              instr_d  = imem.i_data;
              pc_out_d = pc_q;
              pc_p1_d  = pc_inc;
              valid_d  = 1'b1;
            end else begin
              buf_instr_d = imem.i_data;
              buf_pc_d    = pc_q;
              state_d     = S_BUF;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        S_BUF: begin
          if (!stall) begin
            instr_d  = buf_instr_q;
            pc_out_d = buf_pc_q;
            pc_p1_d  = buf_pc_inc;
            valid_d  = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      pc_p1_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      pc_p1_q     <= pc_p1_d;
      valid_q     <= valid_d;
    end
  end

endmodule
